// File: rtl/div_f_pack_if.sv
// Handshake and data bundle between the divider back end and its requester.
interface div_f_pack_if #(
   parameter int RES_WIDTH = 26
);
   logic                 start;
   logic                 sign_in;
   logic [9:0]           exp_in;
   logic [RES_WIDTH-1:0] res_in;
   logic                 nan_in;
   logic                 inf_in;
   logic                 zero_in;
   logic                 busy;
   logic                 valid;
   logic [31:0]          dout;
   logic                 overflow;
   logic                 underflow;
   logic                 inexact;

   modport master (
      output start, sign_in, exp_in, res_in, nan_in, inf_in, zero_in,
      input  busy, valid, dout, overflow, underflow, inexact
   );

   modport slave (
      input  start, sign_in, exp_in, res_in, nan_in, inf_in, zero_in,
      output busy, valid, dout, overflow, underflow, inexact
   );
endinterface

// File: rtl/div_f_pack.sv
// div_f_pack: normalizes a {sign, exp, fixed-point quotient} divide result
// one bit per cycle, handles gradual underflow, overflow and RNE rounding,
// and packs an IEEE-754 single.
// Optional build macro DIV_F_PACK_FTZ_EN: tiny results flush to signed zero
// instead of going through the denormal shifter.
module div_f_pack #(
   parameter int RES_WIDTH = 26,
   parameter int FRAC_BITS = 24
) (
   input  logic        clk,
   input  logic        rst,
   div_f_pack_if.slave bus
);
   // Bits below the guard position that only feed the sticky bit.
   localparam logic [RES_WIDTH-1:0] LOW_MASK =
      (RES_WIDTH'(1) << (FRAC_BITS - 24)) - RES_WIDTH'(1);

`ifdef DIV_F_PACK_FTZ_EN
   typedef enum logic [1:0] {IDLE, NORM, ROUND} state_t;
`else
   typedef enum logic [1:0] {IDLE, NORM, DENORM, ROUND} state_t;
`endif

   state_t                state_q, state_d;
   logic [RES_WIDTH-1:0]  man_q, man_d;
   logic signed [11:0]    exp_q, exp_d;
   logic                  sticky_q, sticky_d;
   logic                  sign_q, sign_d;
   logic                  valid_q, valid_d;
   logic [31:0]           dout_q, dout_d;
   logic                  ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

   logic [23:0]           keep;
   logic                  guard, stk, up, hi;
   logic [24:0]           kr;
   logic [22:0]           mant;
   logic signed [11:0]    e_r;

   // Rounding view of the current mantissa: RNE increment, carry and exponent fixup.
   always_comb begin
      keep  = man_q[FRAC_BITS -: 24];
      guard = man_q[FRAC_BITS-24];
      stk   = sticky_q | (|(man_q & LOW_MASK));
      up    = guard & (stk | keep[0]);
      kr    = {1'b0, keep} + {24'b0, up};
      mant  = kr[24] ? 23'h0 : kr[22:0];
      e_r   = exp_q;
      if (kr[24])
         e_r = exp_q + 12'sd1;
      else if (exp_q == 12'sd0 && kr[23])
         e_r = 12'sd1;                 // denormal rounded up into the min normal
   end

   // Next-state and datapath updates for the start/normalize/round sequence.
   always_comb begin
      state_d  = state_q;
      man_d    = man_q;
      exp_d    = exp_q;
      sticky_d = sticky_q;
      sign_d   = sign_q;
      valid_d  = 1'b0;
      dout_d   = dout_q;
      ovf_d    = ovf_q;
      unf_d    = unf_q;
      inx_d    = inx_q;
      hi       = |(man_q >> (FRAC_BITS + 1));
      case (state_q)
         IDLE: if (bus.start) begin
            sign_d = bus.sign_in;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
            inx_d  = 1'b0;
            if (bus.nan_in) begin
               dout_d  = 32'h7FC0_0000;
               valid_d = 1'b1;
            end else if (bus.inf_in) begin
               dout_d  = {bus.sign_in, 8'hFF, 23'h0};
               valid_d = 1'b1;
            end else if (bus.zero_in || bus.res_in == '0) begin
               dout_d  = {bus.sign_in, 31'h0};
               valid_d = 1'b1;
            end else begin
               man_d    = bus.res_in;
               exp_d    = {{2{bus.exp_in[9]}}, bus.exp_in};
               sticky_d = 1'b0;
               state_d  = NORM;
            end
         end
         NORM: begin
            if (hi) begin
               man_d    = man_q >> 1;
               sticky_d = sticky_q | man_q[0];
               exp_d    = exp_q + 12'sd1;
            end else if (!man_q[FRAC_BITS]) begin
               man_d = man_q << 1;
               exp_d = exp_q - 12'sd1;
            end else if (exp_q <= 12'sd0) begin
`ifdef DIV_F_PACK_FTZ_EN
               dout_d  = {sign_q, 31'h0};
               unf_d   = 1'b1;
               inx_d   = 1'b1;
               valid_d = 1'b1;
               state_d = IDLE;
`else
               state_d = DENORM;
`endif
            end else begin
               state_d = ROUND;
            end
         end
`ifndef DIV_F_PACK_FTZ_EN
         DENORM: begin
            // Stop once the exponent reaches the denormal scale or nothing is left.
            man_d    = man_q >> 1;
            sticky_d = sticky_q | man_q[0];
            exp_d    = exp_q + 12'sd1;
            if (exp_q == 12'sd0 || man_q[RES_WIDTH-1:1] == '0) begin
               exp_d   = 12'sd0;
               state_d = ROUND;
            end
         end
`endif
         ROUND: begin
            state_d = IDLE;
            valid_d = 1'b1;
            if (e_r >= 12'sd255) begin
               dout_d = {sign_q, 8'hFF, 23'h0};
               ovf_d  = 1'b1;
               unf_d  = 1'b0;
               inx_d  = 1'b1;
            end else begin
               dout_d = {sign_q, e_r[7:0], mant};
               ovf_d  = 1'b0;
               unf_d  = (e_r == 12'sd0);
               inx_d  = guard | stk;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and result registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         man_q    <= '0;
         exp_q    <= '0;
         sticky_q <= 1'b0;
         sign_q   <= 1'b0;
         valid_q  <= 1'b0;
         dout_q   <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         inx_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         man_q    <= man_d;
         exp_q    <= exp_d;
         sticky_q <= sticky_d;
         sign_q   <= sign_d;
         valid_q  <= valid_d;
         dout_q   <= dout_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         inx_q    <= inx_d;
      end
   end

   assign bus.busy      = (state_q != IDLE);
   assign bus.valid     = valid_q;
   assign bus.dout      = dout_q;
   assign bus.overflow  = ovf_q;
   assign bus.underflow = unf_q;
   assign bus.inexact   = inx_q;
endmodule

// File: tb/tb_div_f_pack.sv
// Bench for div_f_pack: directed test-plan steps plus random operands checked
// against an arithmetic single-precision packing model.
module tb_div_f_pack;
   localparam int RW = 26;
   localparam int FB = 24;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   ntot = 0, npass = 0, nfail = 0;

   div_f_pack_if #(.RES_WIDTH(RW)) bus ();

   div_f_pack #(.RES_WIDTH(RW), .FRAC_BITS(FB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      ntot++;
      assert (obs === exp_v) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   // Value = r / 2^FB * 2^(e-127); round to nearest even into a single.
   function automatic void model(input logic s, input logic [9:0] e_in, input logic [RW-1:0] r,
                                 input logic n, input logic i, input logic z,
                                 output logic [31:0] d, output logic ov, output logic un,
                                 output logic ix, output int lat);
      int p, big_e, sh, fld, nsh, dsh;
      longint rl, m;
      logic g, st;
      ov = 0; un = 0; ix = 0; lat = 1; d = '0;
      if (n) begin d = 32'h7FC0_0000; return; end
      if (i) begin d = {s, 8'hFF, 23'h0}; return; end
      if (z || r == '0) begin d = {s, 31'h0}; return; end
      p = 0;
      for (int k = 0; k < RW; k++) if (r[k]) p = k;
      big_e = int'($signed(e_in)) + (p - FB);
      nsh   = (p > FB) ? p - FB : FB - p;
      if (big_e >= 1) begin
         sh = p - 23; fld = big_e; dsh = 0;
      end else begin
`ifdef DIV_F_PACK_FTZ_EN
         d = {s, 31'h0}; un = 1; ix = 1; lat = nsh + 2;
         return;
`else
         sh = p - 23 + (1 - big_e); fld = 0;
         dsh = (1 - big_e < FB + 1) ? 1 - big_e : FB + 1;
`endif
      end
      rl = longint'(r);
      if (sh <= 0) begin
         m = rl << (-sh); g = 0; st = 0;
      end else if (sh > 40) begin
         m = 0; g = 0; st = 1;
      end else begin
         m  = rl >> sh;
         g  = ((rl >> (sh - 1)) & 64'sd1) != 0;
         st = (rl & ((64'sd1 << (sh - 1)) - 64'sd1)) != 0;
      end
      ix = g | st;
      if (g && (st || m[0])) m = m + 1;
      if (m == (64'sd1 << 24)) begin m = m >>> 1; fld = fld + 1; end
      if (fld == 0 && m >= (64'sd1 << 23)) fld = 1;
      if (fld >= 255) begin
         d = {s, 8'hFF, 23'h0}; ov = 1; ix = 1;
      end else begin
         d = {s, fld[7:0], m[22:0]}; un = (fld == 0);
      end
      lat = 3 + nsh + dsh;
   endfunction

   // One transaction: latency, busy, result, flags, hold; optional start while busy.
   task automatic run_op(input string tag, input logic s, input logic [9:0] e, input logic [RW-1:0] r,
                         input logic n, input logic i, input logic z, input bit poke);
      logic [31:0] ed;
      logic eo, eu, ex;
      int el, lat, extra;
      model(s, e, r, n, i, z, ed, eo, eu, ex, el);
      @(negedge clk);
      bus.start = 1; bus.sign_in = s; bus.exp_in = e; bus.res_in = r;
      bus.nan_in = n; bus.inf_in = i; bus.zero_in = z;
      @(posedge clk); #1;
      bus.start = 0;
      bus.sign_in = 1'($urandom); bus.exp_in = 10'($urandom); bus.res_in = RW'($urandom);
      bus.nan_in = 1'($urandom); bus.inf_in = 1'($urandom); bus.zero_in = 1'($urandom);
      lat = 1;
      chk({tag, ".busy1"}, 32'(bus.busy), (el == 1) ? 32'd0 : 32'd1);
      if (poke) bus.start = 1;
      while (!bus.valid && lat < 200) begin
         @(posedge clk); #1;
         bus.start = 0;
         lat++;
      end
      bus.start = 0;
      chk({tag, ".lat"}, 32'(lat), 32'(el));
      chk({tag, ".dout"}, bus.dout, ed);
      chk({tag, ".flags"}, {29'h0, bus.overflow, bus.underflow, bus.inexact}, {29'h0, eo, eu, ex});
      chk({tag, ".busyv"}, 32'(bus.busy), 32'd0);
      extra = 0;
      for (int k = 0; k < (poke ? 6 : 1); k++) begin
         @(posedge clk); #1;
         if (bus.valid) extra++;
      end
      chk({tag, ".onevalid"}, 32'(extra), 32'd0);
      chk({tag, ".hold"}, bus.dout, ed);
   endtask

   initial begin
      logic s, n, i, z;
      logic [9:0] e;
      logic [RW-1:0] r;
      int sel, w, cnt;
      bus.start = 0; bus.sign_in = 0; bus.exp_in = '0; bus.res_in = '0;
      bus.nan_in = 0; bus.inf_in = 0; bus.zero_in = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst.out", {bus.busy, bus.valid, bus.overflow, bus.underflow, bus.inexact, 27'h0}, 32'h0);
      chk("rst.dout", bus.dout, 32'h0);
      rst = 0;

      run_op("one", 0, 10'd127, RW'(1) << 24, 0, 0, 0, 0);
      chk("tp.one", bus.dout, 32'h3F80_0000);
      run_op("two", 0, 10'd127, RW'(1) << 25, 0, 0, 0, 0);
      chk("tp.two", bus.dout, 32'h4000_0000);
      run_op("onehalf", 0, 10'd127, RW'(3) << 23, 0, 0, 0, 0);
      chk("tp.onehalf", bus.dout, 32'h3FC0_0000);
      run_op("tie", 0, 10'd127, (RW'(1) << 24) | RW'(1), 0, 0, 0, 0);
      chk("tp.tie", bus.dout, 32'h3F80_0000);
      run_op("rndup", 0, 10'd127, (RW'(1) << 24) | RW'(3), 0, 0, 0, 0);
      run_op("ovf", 0, 10'd300, RW'(1) << 24, 0, 0, 0, 0);
      chk("tp.ovf", bus.dout, 32'h7F80_0000);
      run_op("minnorm", 0, 10'd1, RW'(1) << 24, 0, 0, 0, 0);
      chk("tp.minnorm", bus.dout, 32'h0080_0000);
      run_op("denorm", 0, 10'd0, RW'(1) << 24, 0, 0, 0, 0);
`ifdef DIV_F_PACK_FTZ_EN
      chk("tp.denorm", bus.dout, 32'h0000_0000);
`else
      chk("tp.denorm", bus.dout, 32'h0040_0000);
`endif
      run_op("deep", 1, 10'h200, RW'(5), 0, 0, 0, 0);
      run_op("carry", 0, 10'd126, {RW{1'b1}} >> 1, 0, 0, 0, 0);
      run_op("nan", 0, 10'd5, RW'(7), 1, 1, 0, 0);
      chk("tp.nan", bus.dout, 32'h7FC0_0000);
      run_op("inf", 1, 10'd5, RW'(7), 0, 1, 0, 0);
      chk("tp.inf", bus.dout, 32'hFF80_0000);
      run_op("zero", 0, 10'd5, RW'(7), 0, 0, 1, 0);
      chk("tp.zero", bus.dout, 32'h0000_0000);
      run_op("res0", 1, 10'd127, RW'(0), 0, 0, 0, 0);
      run_op("poke", 0, 10'd127, RW'(1) << 20, 0, 0, 0, 1);

      // Reset in the middle of a long left-normalization.
      @(negedge clk);
      bus.start = 1; bus.sign_in = 1; bus.exp_in = 10'd127; bus.res_in = RW'(1);
      bus.nan_in = 0; bus.inf_in = 0; bus.zero_in = 0;
      @(posedge clk); #1;
      bus.start = 0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1;
      @(posedge clk); #1;
      rst = 0;
      chk("midrst.out", {bus.busy, bus.valid, bus.overflow, bus.underflow, bus.inexact, 27'h0}, 32'h0);
      chk("midrst.dout", bus.dout, 32'h0);
      cnt = 0;
      repeat (40) begin
         @(posedge clk); #1;
         if (bus.valid) cnt++;
      end
      chk("midrst.novalid", 32'(cnt), 32'd0);
      run_op("afterrst", 0, 10'd130, RW'(3) << 22, 0, 0, 0, 0);

      for (int k = 0; k < 40; k++) begin
         s   = 1'($urandom);
         sel = $urandom_range(0, 9);
         case (sel)
            0:       e = 10'($urandom_range(0, 1023));
            1, 2:    e = 10'($urandom_range(0, 4)) - 10'd2;
            3:       e = 10'($urandom_range(250, 258));
            default: e = 10'($urandom_range(100, 160));
         endcase
         w = $urandom_range(1, RW);
         r = RW'($urandom) & RW'((64'd1 << w) - 64'd1);
         n = ($urandom_range(0, 15) == 0);
         i = ($urandom_range(0, 15) == 0);
         z = ($urandom_range(0, 15) == 0);
         run_op("rand", s, e, r, n, i, z, 0);
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end
endmodule
